// File: rtl/sid_reg_writer.sv
// SID register writer: command FIFO drained one write per clkEn with per-command delay.
// Optional shadow register file enabled by SID_REG_WRITER_SHADOW_EN.
module sid_reg_writer #(
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned MAX_ADDR = 'h18
) (
  input  logic                     clk,
  input  logic                     iRstN,
  input  logic                     clkEn,
  input  logic                     iCmdValid,
  input  logic [4:0]               iCmdAddr,
  input  logic [7:0]               iCmdData,
  input  logic [7:0]               iCmdDelay,
  output logic                     oCmdReady,
  output logic                     oWE,
  output logic [4:0]               oAddr,
  output logic [7:0]               oData,
  output logic [$clog2(DEPTH):0]   oLevel,
  output logic                     oIdle
`ifdef SID_REG_WRITER_SHADOW_EN
  ,
  input  logic [4:0]               iRdAddr,
  output logic [7:0]               oRdData
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic [5:0] MAXA = 6'(MAX_ADDR);

  if (DEPTH < 2 || DEPTH > 64 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("DEPTH must be a power of two from 2 to 64");
  end
  if (MAX_ADDR > 31) begin : g_bad_max
    $error("MAX_ADDR must fit the 5-bit address");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  typedef struct packed {
    logic [7:0] delay;
    logic [4:0] addr;
    logic [7:0] data;
  } cmd_t;

  cmd_t          mem [DEPTH];
  cmd_t          head;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   level;
  logic [7:0]    cnt;
  state_t        state;
  logic          push;
  logic          pop;

  assign oCmdReady = (level != FULL);
  assign push      = iCmdValid && oCmdReady;
  assign pop       = (state == IDLE) && clkEn && (level != '0);
  assign head      = mem[rd_ptr];
  assign oLevel    = level;
  assign oIdle     = (state == IDLE) && (level == '0);

  // Storage needs no reset: emptiness is carried by the pointers and level.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{delay: iCmdDelay, addr: iCmdAddr, data: iCmdData};
    end
  end

  always_ff @(posedge clk or negedge iRstN) begin
    if (!iRstN) begin
      state  <= IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      cnt    <= '0;
      oWE    <= 1'b0;
      oAddr  <= '0;
      oData  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop) begin
        level <= level + 1'b1;
      end else if (pop && !push) begin
        level <= level - 1'b1;
      end
      unique case (state)
        IDLE: begin
          if (pop) begin
            state <= ISSUE;
            cnt   <= head.delay;
            // Out-of-range addresses still consume their slot but never strobe.
            if ({1'b0, head.addr} <= MAXA) begin
              oWE   <= 1'b1;
              oAddr <= head.addr;
              oData <= head.data;
            end
          end
        end
        ISSUE: begin
          oWE   <= 1'b0;
          state <= (cnt == '0) ? IDLE : WAIT;
        end
        WAIT: begin
          if (clkEn) begin
            cnt <= cnt - 1'b1;
            if (cnt == 8'd1) state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          oWE   <= 1'b0;
        end
      endcase
    end
  end

`ifdef SID_REG_WRITER_SHADOW_EN
  logic [7:0] shadow [MAX_ADDR+1];

  always_ff @(posedge clk or negedge iRstN) begin
    if (!iRstN) begin
      for (int i = 0; i <= int'(MAX_ADDR); i++) shadow[i] <= '0;
      oRdData <= '0;
    end else begin
      if (oWE) shadow[oAddr] <= oData;
      oRdData <= ({1'b0, iRdAddr} <= MAXA) ? shadow[iRdAddr] : 8'h00;
    end
  end
`endif

endmodule

// File: tb/tb_sid_reg_writer.sv
// Scoreboard bench for sid_reg_writer: randomized and directed command streams.
// Expected writes are queued at push time; a monitor pops them on every oWE.
module tb_sid_reg_writer;
  localparam int DEPTH    = 8;
  localparam int MAX_ADDR = 'h18;

  logic       clk = 1'b0;
  logic       iRstN;
  logic       clkEn;
  logic       iCmdValid;
  logic [4:0] iCmdAddr;
  logic [7:0] iCmdData;
  logic [7:0] iCmdDelay;
  logic       oCmdReady;
  logic       oWE;
  logic [4:0] oAddr;
  logic [7:0] oData;
  logic [3:0] oLevel;
  logic       oIdle;
`ifdef SID_REG_WRITER_SHADOW_EN
  logic [4:0] iRdAddr;
  logic [7:0] oRdData;
`endif

  sid_reg_writer #(.DEPTH(DEPTH), .MAX_ADDR(MAX_ADDR)) dut (
    .clk       (clk),
    .iRstN     (iRstN),
    .clkEn     (clkEn),
    .iCmdValid (iCmdValid),
    .iCmdAddr  (iCmdAddr),
    .iCmdData  (iCmdData),
    .iCmdDelay (iCmdDelay),
    .oCmdReady (oCmdReady),
    .oWE       (oWE),
    .oAddr     (oAddr),
    .oData     (oData),
    .oLevel    (oLevel),
    .oIdle     (oIdle)
`ifdef SID_REG_WRITER_SHADOW_EN
    ,
    .iRdAddr   (iRdAddr),
    .oRdData   (oRdData)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] a;
    logic [7:0] d;
    int         dl;
  } wr_t;

  wr_t exp_q[$];
  int  tick_q[$];
  int  checks = 0;
  int  errors = 0;
  int  period = 0;
  int  tick   = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // clkEn: one clk wide every `period` clocks; tick numbers each pulse.
  initial begin
    int c = 0;
    clkEn = 1'b0;
    forever begin
      @(negedge clk);
      if (period > 0) begin
        c++;
        if (c >= period) begin
          c = 0;
          clkEn = 1'b1;
          tick++;
        end else begin
          clkEn = 1'b0;
        end
      end else begin
        c = 0;
        clkEn = 1'b0;
      end
    end
  end

  // Monitor: every strobe must match the oldest expected write.
  initial begin
    bit  prev_we   = 1'b0;
    bit  have_prev = 1'b0;
    int  last_tick = 0;
    int  last_dl   = 0;
    wr_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!iRstN) begin
        have_prev = 1'b0;
      end else if (oWE) begin
        chk("we_single_cycle", int'(prev_we), 0);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write actual=%0h/%0h required=none",
                   oAddr, oData);
        end else begin
          e = exp_q.pop_front();
          chk("wr_addr", int'(oAddr), int'(e.a));
          chk("wr_data", int'(oData), int'(e.d));
          if (have_prev) begin
            checks++;
            if (tick - last_tick < last_dl + 1) begin
              errors++;
              $display("FAIL wr_spacing actual=%0d required>=%0d",
                       tick - last_tick, last_dl + 1);
            end
          end
          have_prev = 1'b1;
          last_tick = tick;
          last_dl   = e.dl;
        end
        tick_q.push_back(tick);
      end
      prev_we = oWE;
    end
  end

  task automatic push(input logic [4:0] a, input logic [7:0] d,
                      input logic [7:0] dl);
    int n = 0;
    @(negedge clk);
    iCmdValid = 1'b1;
    iCmdAddr  = a;
    iCmdData  = d;
    iCmdDelay = dl;
    while (!oCmdReady && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!oCmdReady) begin
      checks++;
      errors++;
      $display("FAIL push_timeout actual=notready required=ready");
    end else if (int'(a) <= MAX_ADDR) begin
      exp_q.push_back('{a, d, int'(dl)});
    end
    @(negedge clk);
    iCmdValid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(oIdle && exp_q.size() == 0) && n < 20000) begin
      @(negedge clk);
      n++;
    end
    if (!(oIdle && exp_q.size() == 0)) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout actual=%0d_pending required=0", exp_q.size());
    end
  endtask

  initial begin
    int n;
    iRstN     = 1'b0;
    iCmdValid = 1'b0;
    iCmdAddr  = '0;
    iCmdData  = '0;
    iCmdDelay = '0;
`ifdef SID_REG_WRITER_SHADOW_EN
    iRdAddr   = '0;
`endif
    #3;
    chk("rst_we", int'(oWE), 0);
    chk("rst_addr", int'(oAddr), 0);
    chk("rst_data", int'(oData), 0);
    chk("rst_level", int'(oLevel), 0);
    chk("rst_idle", int'(oIdle), 1);
    chk("rst_ready", int'(oCmdReady), 1);
    repeat (3) @(negedge clk);
    iRstN  = 1'b1;
    period = 32;

    // Two zero-delay writes land on consecutive clkEn pulses.
    tick_q.delete();
    push(5'h01, 8'h1C, 8'd0);
    push(5'h00, 8'hD6, 8'd0);
    wait_idle();
    if (tick_q.size() == 2) chk("seq_gap", tick_q[1] - tick_q[0], 1);
    else chk("seq_writes", tick_q.size(), 2);
    chk("seq_idle", int'(oIdle), 1);

    // Delay of 3 puts the next write 4 clkEn pulses later.
    tick_q.delete();
    push(5'h04, 8'h11, 8'd3);
    push(5'h04, 8'h10, 8'd0);
    wait_idle();
    if (tick_q.size() == 2) chk("delay_gap", tick_q[1] - tick_q[0], 4);
    else chk("delay_writes", tick_q.size(), 2);

    // Fill with clkEn stopped; the ninth command must be refused.
    period = 0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < DEPTH; i++) begin
      push(5'($urandom_range(0, MAX_ADDR)), 8'($urandom), 8'd0);
      chk("fill_level", int'(oLevel), i + 1);
    end
    chk("full_ready", int'(oCmdReady), 0);
    @(negedge clk);
    iCmdValid = 1'b1;
    iCmdAddr  = 5'h03;
    iCmdData  = 8'h55;
    iCmdDelay = 8'd0;
    repeat (5) @(negedge clk);
    iCmdValid = 1'b0;
    chk("full_level_hold", int'(oLevel), DEPTH);
    chk("full_ready_hold", int'(oCmdReady), 0);
    period = 4;
    wait_idle();
    chk("drain_level", int'(oLevel), 0);

    // Out-of-range address is consumed without a strobe.
    push(5'h1F, 8'hAA, 8'd0);
    wait_idle();
    chk("oob_level", int'(oLevel), 0);
    chk("oob_idle", int'(oIdle), 1);

    // Randomized stream with random clkEn rate and push gaps.
    period = $urandom_range(2, 8);
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 6)) @(negedge clk);
      push(5'($urandom_range(0, 31)), 8'($urandom), 8'($urandom_range(0, 3)));
    end
    wait_idle();
    chk("rand_level", int'(oLevel), 0);

    // Reset during WAIT with three commands still queued.
    period = 4;
    push(5'h02, 8'h33, 8'd20);
    push(5'h05, 8'h01, 8'd0);
    push(5'h06, 8'h02, 8'd0);
    push(5'h07, 8'h03, 8'd0);
    n = 0;
    while (exp_q.size() != 3 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("wait_pending", exp_q.size(), 3);
    repeat (3) @(negedge clk);
    iRstN = 1'b0;
    #1;
    chk("arst_we", int'(oWE), 0);
    chk("arst_level", int'(oLevel), 0);
    chk("arst_idle", int'(oIdle), 1);
    chk("arst_ready", int'(oCmdReady), 1);
    chk("arst_addr", int'(oAddr), 0);
    exp_q.delete();
    @(negedge clk);
    iRstN = 1'b1;
    repeat (200) @(negedge clk);
    chk("post_rst_level", int'(oLevel), 0);
    push(5'h09, 8'h77, 8'd0);
    wait_idle();

    // Reset while the strobe is high drops it at once.
    push(5'h03, 8'h44, 8'd0);
    n = 0;
    while (!oWE && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("issue_seen", int'(oWE), 1);
    #1;
    iRstN = 1'b0;
    #1;
    chk("issue_rst_we", int'(oWE), 0);
    exp_q.delete();
    @(negedge clk);
    iRstN = 1'b1;

`ifdef SID_REG_WRITER_SHADOW_EN
    push(5'h18, 8'h0F, 8'd0);
    wait_idle();
    @(negedge clk);
    iRdAddr = 5'h18;
    @(negedge clk);
    chk("shadow_rd", int'(oRdData), 'h0F);
    iRdAddr = 5'h1A;
    @(negedge clk);
    chk("shadow_oob", int'(oRdData), 0);
`endif

    repeat (10) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
